// File: rtl/multiplexador_writeback.sv
// -----------------------------------------------------------------------------
// multiplexador_writeback
//
// Registered write-back selector for the final pipeline stage. Picks the
// register-file write data from memory read data (Selecao = 0) or from one of
// NUM_FONTES packed sources (Selecao = k selects slice k-1). A memory select
// whose data is not valid on the accept cycle parks the block in AGUARDA_MEM
// until DadoLido_Valido arrives or TIMEOUT_CICLOS cycles elapse.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   Valido_Entrada         upstream instruction valid
//   Pronto_Entrada         block can accept (high only in OCIOSO)
//   Selecao                source select
//   Dados_Fontes           packed non-memory sources
//   EscreveReg_Entrada     instruction writes the register file
//   Endereco_Destino       destination register
//   DadoLido_Mem           memory read data
//   DadoLido_Valido        memory read data valid this cycle
//   Escolhido              registered write-back data
//   Endereco_Escrita       registered write address
//   EscreveReg             write enable, one-cycle pulse
//   Valido_Saida           one-cycle pulse per completed write-back slot
//   Erro_Selecao           one-cycle pulse: Selecao out of range
//   Erro_Timeout           one-cycle pulse: memory data never arrived
// -----------------------------------------------------------------------------
module multiplexador_writeback #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_FONTES     = 3,
   parameter int unsigned SEL_WIDTH      = 2,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned TIMEOUT_CICLOS = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             Valido_Entrada,
   output logic                             Pronto_Entrada,
   input  logic [SEL_WIDTH-1:0]             Selecao,
   input  logic [NUM_FONTES*DATA_WIDTH-1:0] Dados_Fontes,
   input  logic                             EscreveReg_Entrada,
   input  logic [REG_ADDR_WIDTH-1:0]        Endereco_Destino,
   input  logic [DATA_WIDTH-1:0]            DadoLido_Mem,
   input  logic                             DadoLido_Valido,
   output logic [DATA_WIDTH-1:0]            Escolhido,
   output logic [REG_ADDR_WIDTH-1:0]        Endereco_Escrita,
   output logic                             EscreveReg,
   output logic                             Valido_Saida,
   output logic                             Erro_Selecao,
   output logic                             Erro_Timeout
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CICLOS + 1);

   localparam logic [0:0] OCIOSO      = 1'b0;
   localparam logic [0:0] AGUARDA_MEM = 1'b1;

   localparam logic [SEL_WIDTH-1:0] SelMax    = SEL_WIDTH'(NUM_FONTES);
   localparam logic [CntW-1:0]      CntLimite = CntW'(TIMEOUT_CICLOS);

   logic [0:0]                estado_q, estado_d;
   logic [CntW-1:0]           cont_q, cont_d;
   logic [REG_ADDR_WIDTH-1:0] end_lat_q, end_lat_d;
   logic                      esc_lat_q, esc_lat_d;
   logic [DATA_WIDTH-1:0]     escolhido_q, escolhido_d;
   logic [REG_ADDR_WIDTH-1:0] end_esc_q, end_esc_d;
   logic                      escreve_q, escreve_d;
   logic                      valido_q, valido_d;
   logic                      erro_sel_q, erro_sel_d;
   logic                      erro_to_q, erro_to_d;

   logic [DATA_WIDTH-1:0]     fonte;
   logic                      sel_invalida;

   // Slice k-1 of Dados_Fontes for Selecao = k; zero for memory/out-of-range.
   always_comb begin
      fonte = '0;
      for (int i = 0; i < NUM_FONTES; i++) begin
         if (Selecao == SEL_WIDTH'(i + 1)) begin
            fonte = Dados_Fontes[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sel_invalida   = (Selecao > SelMax);
   assign Pronto_Entrada = (estado_q == OCIOSO);

   always_comb begin
      estado_d    = estado_q;
      cont_d      = cont_q;
      end_lat_d   = end_lat_q;
      esc_lat_d   = esc_lat_q;
      escolhido_d = escolhido_q;
      end_esc_d   = end_esc_q;
      escreve_d   = 1'b0;
      valido_d    = 1'b0;
      erro_sel_d  = 1'b0;
      erro_to_d   = 1'b0;

      case (estado_q)
         OCIOSO: begin
            if (Valido_Entrada) begin
               end_lat_d = Endereco_Destino;
               esc_lat_d = EscreveReg_Entrada;
               if (sel_invalida) begin
                  escolhido_d = '0;
                  end_esc_d   = Endereco_Destino;
                  valido_d    = 1'b1;
                  erro_sel_d  = 1'b1;
               end else if (Selecao == '0) begin
                  if (DadoLido_Valido) begin
                     escolhido_d = DadoLido_Mem;
                     end_esc_d   = Endereco_Destino;
                     escreve_d   = EscreveReg_Entrada & (|Endereco_Destino);
                     valido_d    = 1'b1;
                  end else begin
                     estado_d = AGUARDA_MEM;
                     cont_d   = CntW'(1);
                  end
               end else begin
                  escolhido_d = fonte;
                  end_esc_d   = Endereco_Destino;
                  escreve_d   = EscreveReg_Entrada & (|Endereco_Destino);
                  valido_d    = 1'b1;
               end
            end
         end
         AGUARDA_MEM: begin
            if (DadoLido_Valido) begin
               escolhido_d = DadoLido_Mem;
               end_esc_d   = end_lat_q;
               escreve_d   = esc_lat_q & (|end_lat_q);
               valido_d    = 1'b1;
               estado_d    = OCIOSO;
               cont_d      = '0;
            end else if (cont_q == CntLimite) begin
               // Give up: slot completes with an error, data register untouched.
               end_esc_d = end_lat_q;
               valido_d  = 1'b1;
               erro_to_d = 1'b1;
               estado_d  = OCIOSO;
               cont_d    = '0;
            end else begin
               cont_d = cont_q + CntW'(1);
            end
         end
         default: begin
            estado_d = OCIOSO;
            cont_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q    <= OCIOSO;
         cont_q      <= '0;
         end_lat_q   <= '0;
         esc_lat_q   <= 1'b0;
         escolhido_q <= '0;
         end_esc_q   <= '0;
         escreve_q   <= 1'b0;
         valido_q    <= 1'b0;
         erro_sel_q  <= 1'b0;
         erro_to_q   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         cont_q      <= cont_d;
         end_lat_q   <= end_lat_d;
         esc_lat_q   <= esc_lat_d;
         escolhido_q <= escolhido_d;
         end_esc_q   <= end_esc_d;
         escreve_q   <= escreve_d;
         valido_q    <= valido_d;
         erro_sel_q  <= erro_sel_d;
         erro_to_q   <= erro_to_d;
      end
   end

   assign Escolhido        = escolhido_q;
   assign Endereco_Escrita = end_esc_q;
   assign EscreveReg       = escreve_q;
   assign Valido_Saida     = valido_q;
   assign Erro_Selecao     = erro_sel_q;
   assign Erro_Timeout     = erro_to_q;

endmodule

// File: tb/tb_multiplexador_writeback.sv
// -----------------------------------------------------------------------------
// tb_multiplexador_writeback
//
// Directed bench for multiplexador_writeback. The main instance uses the
// default parameters and is checked through a scoreboard of expected
// completions; a second instance with NUM_FONTES=2 covers out-of-range select.
// -----------------------------------------------------------------------------
module tb_multiplexador_writeback;

   logic        clock;
   logic        reset;

   // Main instance (NUM_FONTES = 3)
   logic        valido_in;
   logic        pronto;
   logic [1:0]  sel;
   logic [95:0] fontes;
   logic        we_in;
   logic [4:0]  addr_in;
   logic [31:0] mem;
   logic        mem_v;
   logic [31:0] escolhido;
   logic [4:0]  end_esc;
   logic        escreve;
   logic        valido_out;
   logic        erro_sel;
   logic        erro_to;

   // Second instance (NUM_FONTES = 2)
   logic        valido_in2;
   logic        pronto2;
   logic [1:0]  sel2;
   logic [63:0] fontes2;
   logic        we_in2;
   logic [4:0]  addr_in2;
   logic [31:0] mem2;
   logic        mem_v2;
   logic [31:0] escolhido2;
   logic [4:0]  end_esc2;
   logic        escreve2;
   logic        valido_out2;
   logic        erro_sel2;
   logic        erro_to2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        we;
      logic        es;
      logic        et;
      logic        ck_addr;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prev_data = 32'h0;

   multiplexador_writeback dut (
      .clock              (clock),
      .reset              (reset),
      .Valido_Entrada     (valido_in),
      .Pronto_Entrada     (pronto),
      .Selecao            (sel),
      .Dados_Fontes       (fontes),
      .EscreveReg_Entrada (we_in),
      .Endereco_Destino   (addr_in),
      .DadoLido_Mem       (mem),
      .DadoLido_Valido    (mem_v),
      .Escolhido          (escolhido),
      .Endereco_Escrita   (end_esc),
      .EscreveReg         (escreve),
      .Valido_Saida       (valido_out),
      .Erro_Selecao       (erro_sel),
      .Erro_Timeout       (erro_to)
   );

   multiplexador_writeback #(
      .DATA_WIDTH     (32),
      .NUM_FONTES     (2),
      .SEL_WIDTH      (2),
      .REG_ADDR_WIDTH (5),
      .TIMEOUT_CICLOS (16)
   ) dut2 (
      .clock              (clock),
      .reset              (reset),
      .Valido_Entrada     (valido_in2),
      .Pronto_Entrada     (pronto2),
      .Selecao            (sel2),
      .Dados_Fontes       (fontes2),
      .EscreveReg_Entrada (we_in2),
      .Endereco_Destino   (addr_in2),
      .DadoLido_Mem       (mem2),
      .DadoLido_Valido    (mem_v2),
      .Escolhido          (escolhido2),
      .Endereco_Escrita   (end_esc2),
      .EscreveReg         (escreve2),
      .Valido_Saida       (valido_out2),
      .Erro_Selecao       (erro_sel2),
      .Erro_Timeout       (erro_to2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic [4:0] a, input logic we,
                       input logic es, input logic et, input logic ca);
      exp_t e;
      e.data    = d;
      e.addr    = a;
      e.we      = we;
      e.es      = es;
      e.et      = et;
      e.ck_addr = ca;
      sb.push_back(e);
      if (!et) prev_data = es ? 32'h0 : d;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard monitor for the main instance, sampled away from the edge.
   always @(negedge clock) begin
      if (reset) begin
         if (valido_out) begin
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("wb_data", escolhido, e.data);
               if (e.ck_addr) chk("wb_addr", 32'(end_esc), 32'(e.addr));
               chk("wb_we", 32'(escreve), 32'(e.we));
               chk("wb_err_sel", 32'(erro_sel), 32'(e.es));
               chk("wb_err_to", 32'(erro_to), 32'(e.et));
            end else begin
               chk("stray_valid", 32'(valido_out), 32'(1'b0));
            end
         end else begin
            chk("idle_pulses", 32'(escreve | erro_sel | erro_to), 32'(1'b0));
         end
      end
   end

   initial begin
      int pulses;
      reset      = 1'b1;
      valido_in  = 1'b0;
      sel        = 2'd0;
      fontes     = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
      we_in      = 1'b0;
      addr_in    = 5'd0;
      mem        = 32'h0;
      mem_v      = 1'b0;
      valido_in2 = 1'b0;
      sel2       = 2'd0;
      fontes2    = {32'h22220002, 32'h11110001};
      we_in2     = 1'b0;
      addr_in2   = 5'd0;
      mem2       = 32'h0;
      mem_v2     = 1'b0;

      #1 reset = 1'b0;
      #2;
      chk("rst_escolhido", escolhido, 0);
      chk("rst_endereco", 32'(end_esc), 0);
      chk("rst_escreve", 32'(escreve), 0);
      chk("rst_valido", 32'(valido_out), 0);
      chk("rst_err_sel", 32'(erro_sel), 0);
      chk("rst_err_to", 32'(erro_to), 0);
      chk("rst_pronto", 32'(pronto), 1);
      repeat (2) @(negedge clock);
      #1 reset = 1'b1;

      // Back-to-back source selects
      step();
      valido_in = 1'b1; we_in = 1'b1; addr_in = 5'd7;
      sel = 2'd1; push(32'hAAAA0001, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("b2b_pronto1", 32'(pronto), 1);
      step();
      sel = 2'd2; push(32'hBBBB0002, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("b2b_pronto2", 32'(pronto), 1);
      step();
      sel = 2'd3; push(32'hCCCC0003, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("b2b_pronto3", 32'(pronto), 1);
      step();
      valido_in = 1'b0;

      // Memory data valid on the accept cycle
      step();
      valido_in = 1'b1; sel = 2'd0; addr_in = 5'd5; mem = 32'h12345678; mem_v = 1'b1;
      push(32'h12345678, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      valido_in = 1'b0; mem_v = 1'b0;

      // Late memory data, with a new instruction held during the wait
      step();
      valido_in = 1'b1; sel = 2'd0; addr_in = 5'd9;
      push(32'hDEADBEEF, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      sel = 2'd1; addr_in = 5'd10;
      chk("wait_pronto1", 32'(pronto), 0);
      step();
      chk("wait_pronto2", 32'(pronto), 0);
      step();
      chk("wait_pronto3", 32'(pronto), 0);
      mem = 32'hDEADBEEF; mem_v = 1'b1;
      step();
      chk("late_valid", 32'(valido_out), 1);
      chk("late_we", 32'(escreve), 1);
      chk("late_pronto", 32'(pronto), 1);
      mem_v = 1'b0; mem = 32'h0;
      push(32'hAAAA0001, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      valido_in = 1'b0;

      // Memory never valid: timeout 16 cycles after accept
      step();
      valido_in = 1'b1; sel = 2'd0; addr_in = 5'd12;
      push(prev_data, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      valido_in = 1'b0;
      for (int k = 1; k < 16; k++) begin
         step();
         chk("to_early", 32'(erro_to | valido_out), 0);
      end
      step();
      chk("to_pulse", 32'(erro_to), 1);
      chk("to_valid", 32'(valido_out), 1);
      chk("to_we", 32'(escreve), 0);
      chk("to_pronto", 32'(pronto), 1);

      // Write to register 0 is suppressed, data still reported
      step();
      valido_in = 1'b1; sel = 2'd2; addr_in = 5'd0; we_in = 1'b1;
      push(32'hBBBB0002, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      valido_in = 1'b0;

      // Out-of-range select on the NUM_FONTES=2 instance
      step();
      valido_in2 = 1'b1; sel2 = 2'd2; addr_in2 = 5'd4; we_in2 = 1'b1;
      step();
      sel2 = 2'd3;
      chk("n2_data", escolhido2, 32'h22220002);
      chk("n2_we", 32'(escreve2), 1);
      step();
      valido_in2 = 1'b0;
      chk("n2_err_sel", 32'(erro_sel2), 1);
      chk("n2_err_data", escolhido2, 0);
      chk("n2_err_we", 32'(escreve2), 0);
      chk("n2_err_valid", 32'(valido_out2), 1);
      step();
      chk("n2_err_pulse_end", 32'(erro_sel2), 0);

      // Asynchronous reset while waiting for memory
      step();
      valido_in = 1'b1; sel = 2'd0; addr_in = 5'd3; we_in = 1'b1;
      step();
      valido_in = 1'b0;
      step();
      chk("mid_pronto", 32'(pronto), 0);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_escolhido", escolhido, 0);
      chk("mid_rst_endereco", 32'(end_esc), 0);
      chk("mid_rst_pulses", 32'(escreve | valido_out | erro_sel | erro_to), 0);
      chk("mid_rst_pronto", 32'(pronto), 1);
      @(negedge clock);
      #1 reset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (valido_out | escreve | erro_to) pulses++;
      end
      chk("post_rst_pulses", 32'(pulses), 0);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiplexador_writeback.md
Name: multiplexador_writeback

Overview:
Parametrised, registered write-back selector for the processor's final pipeline stage. Chooses the register-file write data from memory read data or one of NUM_FONTES other sources (ULA result, PC+4, immediate, ...). Waits for late memory data under a valid handshake, with a timeout. Drives the register-file write port (data, address, enable) one cycle after the selection resolves.

Parameters:
DATA_WIDTH, 32, width of every data source and of the output
NUM_FONTES, 3, number of non-memory sources packed in Dados_Fontes (1..15)
SEL_WIDTH, 2, width of Selecao; must satisfy 2^SEL_WIDTH >= NUM_FONTES+1
REG_ADDR_WIDTH, 5, register-file address width
TIMEOUT_CICLOS, 16, maximum wait cycles for memory data (>=1)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
Valido_Entrada  input  1  upstream instruction valid
Pronto_Entrada  output  1  block can accept (combinational from state)
Selecao  input  SEL_WIDTH  0 = memory, k = Dados_Fontes slice k-1 (k=1..NUM_FONTES)
Dados_Fontes  input  NUM_FONTES*DATA_WIDTH  packed sources; slice i at bits [i*DATA_WIDTH +: DATA_WIDTH]
EscreveReg_Entrada  input  1  instruction writes the register file
Endereco_Destino  input  REG_ADDR_WIDTH  destination register
DadoLido_Mem  input  DATA_WIDTH  memory read data
DadoLido_Valido  input  1  memory read data valid this cycle
Escolhido  output  DATA_WIDTH  registered write-back data
Endereco_Escrita  output  REG_ADDR_WIDTH  registered write address
EscreveReg  output  1  registered write enable, one-cycle pulse
Valido_Saida  output  1  one-cycle pulse: write-back slot completed
Erro_Selecao  output  1  one-cycle pulse: Selecao > NUM_FONTES
Erro_Timeout  output  1  one-cycle pulse: memory data never arrived

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO; Escolhido=0; Endereco_Escrita=0; EscreveReg=0; Valido_Saida=0; Erro_Selecao=0; Erro_Timeout=0; wait counter=0. Reset mid-wait abandons the pending instruction with no write and no error pulse.
- States: OCIOSO, AGUARDA_MEM. Pronto_Entrada = (estado == OCIOSO).
- Accept = Valido_Entrada & Pronto_Entrada. Address and EscreveReg_Entrada are latched on accept.
- Accept with Selecao in 1..NUM_FONTES: next edge sets Escolhido = selected slice and Valido_Saida=1. Latency is 1 cycle. State stays OCIOSO, so back-to-back accepts are allowed every cycle.
- Accept with Selecao = 0 and DadoLido_Valido=1 in the same cycle: same as above with DadoLido_Mem. Latency is 1 cycle.
- Accept with Selecao = 0 and DadoLido_Valido=0: go to AGUARDA_MEM and set the counter to 1.
  - In AGUARDA_MEM, each cycle with DadoLido_Valido=1 captures the data. The next edge outputs it with Valido_Saida=1 and returns to OCIOSO.
  - Otherwise the counter increments. If the counter == TIMEOUT_CICLOS and data is not valid, the next edge pulses Erro_Timeout=1 and Valido_Saida=1 with EscreveReg=0. Escolhido holds its previous value. Return to OCIOSO.
- Selecao > NUM_FONTES on accept: Escolhido=0, EscreveReg=0, Erro_Selecao=1, Valido_Saida=1, latency 1. No wait.
- EscreveReg = latched EscreveReg_Entrada & (latched address != 0) & no error, asserted only in the Valido_Saida cycle. Writes to register 0 are suppressed while data is still output.
- DadoLido_Valido in OCIOSO without a memory-select accept is ignored.
- Outside completion cycles: EscreveReg, Valido_Saida and the error pulses are 0. Escolhido and Endereco_Escrita hold their last values.
- No arithmetic; data passes through bit-exact.

Test Plan:
- Reset then back-to-back accepts with Selecao=1,2,3, Dados_Fontes = {0xCCCC0003, 0xBBBB0002, 0xAAAA0001}, address 7, EscreveReg_Entrada=1 -> Escolhido = 0xAAAA0001, 0xBBBB0002, 0xCCCC0003 on consecutive cycles. EscreveReg=1 and Endereco_Escrita=7 each cycle. Pronto_Entrada stays 1.
- Selecao=0, DadoLido_Valido=1 with DadoLido_Mem=0x12345678 on the accept cycle -> next cycle Escolhido=0x12345678, Valido_Saida=1.
- Selecao=0, DadoLido_Valido asserted 3 cycles after accept with 0xDEADBEEF -> Pronto_Entrada=0 for 3 cycles. Write pulse one cycle after valid. A new Valido_Entrada held during the wait is accepted only after return to OCIOSO.
- Selecao=0, memory never valid, TIMEOUT_CICLOS=16 -> Erro_Timeout=1 and Valido_Saida=1 with EscreveReg=0 exactly 16 cycles after accept. Then Pronto_Entrada=1.
- Selecao=3 with NUM_FONTES=2 -> Erro_Selecao=1, Escolhido=0, EscreveReg=0. Separately, address 0 with valid data -> EscreveReg=0, Valido_Saida=1.
- reset=0 asserted asynchronously mid-clock while in AGUARDA_MEM -> all outputs 0 immediately. No write and no error pulse after release.
